id_wide: RTL and testbench
==========================

Name: id_wide

Overview:
Parametrised N-lane instruction decode stage for the out-of-order core, placed between the fetch stage and the ROB/reservation-station dispatch. Each cycle it accepts a group of up to WIDTH instructions. For each lane it:
- classifies register usage (source/destination extraction),
- drives regfile read ports,
- detects dependencies between lanes of the same group.

Results are registered into a one-entry output stage with a valid/ready handshake and flush. This generalises the single-lane ID stage: multiple lanes, backpressure, intra-group hazard tracking.

Parameters:
WIDTH, 2, number of decode lanes (1..8)
ADDR_W, 32, PC width
GHR_W, 5, PHT index width carried from IF
LW, $clog2(WIDTH) (minimum 1), lane-index width (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  discard the held group and the incoming group
in_valid  in  1  group offered by IF
in_ready  out  1  group accepted when in_valid&&in_ready
in_lane_mask  in  WIDTH  per-lane valid
in_pc  in  WIDTH*ADDR_W  lane k at bits [k*ADDR_W +: ADDR_W]
in_inst  in  WIDTH*32  instruction words
in_is_branch_taken  in  WIDTH  prediction bits
in_pht_index  in  WIDTH*GHR_W  PHT indices
reg_read_en  out  2*WIDTH  port 2k = rs of lane k, port 2k+1 = rt of lane k
reg_read_addr  out  2*WIDTH*5  read addresses
reg_read_is_rsid  in  2*WIDTH  data is an RS id (value pending)
reg_read_data  in  2*WIDTH*32  read data, same cycle
out_valid  out  1  held group valid
out_ready  in  1  downstream accepts the group
out_lane_mask, out_pc, out_inst, out_is_branch_taken, out_pht_index  out  as inputs  registered copies
out_opnd_en  out  2*WIDTH  operand is used
out_opnd_data  out  2*WIDTH*32  latched read data
out_opnd_is_rsid  out  2*WIDTH  latched rsid flag
out_opnd_dep  out  2*WIDTH  operand produced by an earlier lane of the same group
out_opnd_dep_lane  out  2*WIDTH*LW  producer lane index
out_write_en  out  WIDTH  lane writes a register
out_write_addr  out  WIDTH*5  destination register

Behaviour:
Decode is combinational on the input group, per lane, with opcode = inst[31:26].
- opcode 0 (R-type): reads rs and rt; writes rd. JR/JALR (funct 0x08/0x09) read rs only; JALR writes rd.
- 0x08–0x0F and loads 0x20–0x25: read rs; write rt. LUI (0x0F) reads nothing.
- Stores 0x28–0x2B and BEQ/BNE (0x04/0x05): read rs and rt; no write.
- REGIMM/BLEZ/BGTZ (0x01, 0x06, 0x07): read rs. BLTZAL/BGEZAL also write r31.
- J (0x02): no reads, no write. JAL (0x03): writes r31.
- Any other opcode: no reads, no write.

Per-operand and per-lane rules:
- A source equal to $0: read_en=0, opnd_en=0, data=0, is_rsid=0, dep=0.
- A write to $0: write_en=0.
- A lane with mask bit 0: all read_en=0 and all out fields for that lane are zero.
- Read ports are driven only when in_valid&&in_ready.

Intra-group dependency:
- For lane j operand r, dep=1 when some lane i<j has write_en with write_addr==r.
- dep_lane is the highest such i (the nearest producer).
- When dep=1, the latched is_rsid is 0 and the data is don't-care (downstream uses the producer's tag).

Handshake and latency:
- in_ready = !out_valid || out_ready. This gives full throughput with a 1-cycle latency.
- On an accept, all outputs load at the next rising edge and out_valid=1.
- If out_valid && !out_ready, all outputs hold stable.
- If out_valid && out_ready and there is no new accept, out_valid falls to 0.
- flush has priority: out_valid=0 at the next edge, the input is not captured, and in_ready is unaffected combinationally.

Reset:
- rst low clears out_valid and every out_* register to 0 immediately (asynchronous), including mid-stall.
- After release, in_ready=1.

Optional Feature:
Macro: ID_PERF_CNT_EN.
- Defined: adds outputs perf_group_cnt (32) and perf_stall_cnt (32), plus a 1-bit input perf_clear.
  - group_cnt increments on each accept.
  - stall_cnt increments each cycle with in_valid && !in_ready.
  - Both counters wrap modulo 2^32, clear on rst or perf_clear, and perf_clear wins over increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. WIDTH=2; lane0 0x00221821 (addu $3,$1,$2), lane1 0x24640001 (addiu $4,$3,1); reg1=5, reg2=7 → next cycle out_valid=1; lane0 opnd data 5/7; write_en0=1, addr 3; lane1 opnd0 dep=1, dep_lane=0; write_addr1=4.
2. lane0 0x0C000010 (jal), lane1 0x00000000 → write_en0=1, addr 31; lane1 all reads disabled; write_en1=0 (rd=$0).
3. out_ready=0 for 3 cycles with a new group offered → in_ready=0 and outputs frozen; out_ready=1 → next group loads one cycle later.
4. out_valid=1, flush=1 with in_valid=1 → out_valid=0 next cycle; the flushed group never appears.
5. rst asserted low during a stalled group → out_valid=0 asynchronously; after release in_ready=1 and the first group decodes correctly.
6. With ID_PERF_CNT_EN: 4 accepts and 2 stall cycles → group_cnt=4, stall_cnt=2; perf_clear → both 0.

Source files
------------

// File: rtl/id_wide.sv
// id_wide: WIDTH-lane instruction decode with intra-group hazard tracking and a
// one-entry valid/ready output stage. Optional counters under ID_PERF_CNT_EN.
module id_wide #(
    parameter int WIDTH  = 2,
    parameter int ADDR_W = 32,
    parameter int GHR_W  = 5,
    localparam int LW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
`ifdef ID_PERF_CNT_EN
    input  logic                      perf_clear,
    output logic [31:0]               perf_group_cnt,
    output logic [31:0]               perf_stall_cnt,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_lane_mask,
    input  logic [WIDTH*ADDR_W-1:0]   in_pc,
    input  logic [WIDTH*32-1:0]       in_inst,
    input  logic [WIDTH-1:0]          in_is_branch_taken,
    input  logic [WIDTH*GHR_W-1:0]    in_pht_index,
    output logic [2*WIDTH-1:0]        reg_read_en,
    output logic [2*WIDTH*5-1:0]      reg_read_addr,
    input  logic [2*WIDTH-1:0]        reg_read_is_rsid,
    input  logic [2*WIDTH*32-1:0]     reg_read_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_lane_mask,
    output logic [WIDTH*ADDR_W-1:0]   out_pc,
    output logic [WIDTH*32-1:0]       out_inst,
    output logic [WIDTH-1:0]          out_is_branch_taken,
    output logic [WIDTH*GHR_W-1:0]    out_pht_index,
    output logic [2*WIDTH-1:0]        out_opnd_en,
    output logic [2*WIDTH*32-1:0]     out_opnd_data,
    output logic [2*WIDTH-1:0]        out_opnd_is_rsid,
    output logic [2*WIDTH-1:0]        out_opnd_dep,
    output logic [2*WIDTH*LW-1:0]     out_opnd_dep_lane,
    output logic [WIDTH-1:0]          out_write_en,
    output logic [WIDTH*5-1:0]        out_write_addr
);

    typedef struct packed {
        logic       use_rs;
        logic       use_rt;
        logic       wr_en;
        logic [4:0] wr_addr;
    } dec_t;

    // Register usage of one instruction; sources/destinations equal to $0 are dropped.
    function automatic dec_t decode(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [5:0] funct);
        dec_t d;
        d = '0;
        case (op) inside
            6'h00: begin
                d.use_rs = 1'b1;
                if (funct == 6'h08) begin
                    d.use_rt = 1'b0;
                end else if (funct == 6'h09) begin
                    d.wr_en   = 1'b1;
                    d.wr_addr = rd;
                end else begin
                    d.use_rt  = 1'b1;
                    d.wr_en   = 1'b1;
                    d.wr_addr = rd;
                end
            end
            [6'h08:6'h0E], [6'h20:6'h25]: begin
                d.use_rs  = 1'b1;
                d.wr_en   = 1'b1;
                d.wr_addr = rt;
            end
            6'h0F: begin
                d.wr_en   = 1'b1;
                d.wr_addr = rt;
            end
            [6'h28:6'h2B], 6'h04, 6'h05: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            6'h01: begin
                d.use_rs = 1'b1;
                if (rt == 5'h10 || rt == 5'h11) begin
                    d.wr_en   = 1'b1;
                    d.wr_addr = 5'd31;
                end
            end
            6'h06, 6'h07: d.use_rs = 1'b1;
            6'h03: begin
                d.wr_en   = 1'b1;
                d.wr_addr = 5'd31;
            end
            default: d = '0;
        endcase
        if (rs == 5'd0) d.use_rs = 1'b0;
        if (rt == 5'd0) d.use_rt = 1'b0;
        if (!d.wr_en || d.wr_addr == 5'd0) begin
            d.wr_en   = 1'b0;
            d.wr_addr = 5'd0;
        end
        return d;
    endfunction

    dec_t dec [WIDTH];
    logic accept;
    logic capture;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign capture  = accept && !flush;

    always_comb begin : decode_lanes
        for (int k = 0; k < WIDTH; k++) begin
            dec[k] = in_lane_mask[k] ?
                     decode(in_inst[k*32+26 +: 6], in_inst[k*32+21 +: 5], in_inst[k*32+16 +: 5],
                            in_inst[k*32+11 +: 5], in_inst[k*32 +: 6]) : '0;
        end
    end

    logic [2*WIDTH-1:0]      nxt_opnd_en;
    logic [2*WIDTH*32-1:0]   nxt_opnd_data;
    logic [2*WIDTH-1:0]      nxt_opnd_is_rsid;
    logic [2*WIDTH-1:0]      nxt_opnd_dep;
    logic [2*WIDTH*LW-1:0]   nxt_opnd_dep_lane;
    logic [WIDTH-1:0]        nxt_write_en;
    logic [WIDTH*5-1:0]      nxt_write_addr;
    logic [WIDTH*ADDR_W-1:0] nxt_pc;
    logic [WIDTH*32-1:0]     nxt_inst;
    logic [WIDTH-1:0]        nxt_bt;
    logic [WIDTH*GHR_W-1:0]  nxt_pht;

    always_comb begin : operands
        logic [4:0]    src;
        logic          used;
        logic          dep;
        logic [LW-1:0] dep_lane;
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        src               = '0;
        used              = 1'b0;
        dep               = 1'b0;
        dep_lane          = '0;
        reg_read_en       = '0;
        reg_read_addr     = '0;
        nxt_opnd_en       = '0;
        nxt_opnd_data     = '0;
        nxt_opnd_is_rsid  = '0;
        nxt_opnd_dep      = '0;
        nxt_opnd_dep_lane = '0;
        nxt_write_en      = '0;
        nxt_write_addr    = '0;
        nxt_pc            = '0;
        nxt_inst          = '0;
        nxt_bt            = '0;
        nxt_pht           = '0;
        for (int j = 0; j < WIDTH; j++) begin
            nxt_write_en[j]        = dec[j].wr_en;
            nxt_write_addr[j*5 +: 5] = dec[j].wr_addr;
            if (in_lane_mask[j]) begin
                nxt_pc[j*ADDR_W +: ADDR_W] = in_pc[j*ADDR_W +: ADDR_W];
                nxt_inst[j*32 +: 32]       = in_inst[j*32 +: 32];
                nxt_bt[j]                  = in_is_branch_taken[j];
                nxt_pht[j*GHR_W +: GHR_W]  = in_pht_index[j*GHR_W +: GHR_W];
            end
            for (int p = 0; p < 2; p++) begin
                src      = (p == 0) ? in_inst[j*32+21 +: 5] : in_inst[j*32+16 +: 5];
                used     = (p == 0) ? dec[j].use_rs : dec[j].use_rt;
                dep      = 1'b0;
                dep_lane = '0;
                // Later lanes overwrite, leaving the nearest earlier producer.
                for (int i = 0; i < WIDTH; i++) begin
                    if (i < j && used && dec[i].wr_en && dec[i].wr_addr == src) begin
                        dep      = 1'b1;
                        dep_lane = LW'(i);
                    end
                end
                reg_read_en[2*j+p]                 = used && accept;
                reg_read_addr[(2*j+p)*5 +: 5]      = (used && accept) ? src : 5'd0;
                nxt_opnd_en[2*j+p]                 = used;
                nxt_opnd_dep[2*j+p]                = dep;
                nxt_opnd_dep_lane[(2*j+p)*LW +: LW] = dep_lane;
                if (used && !dep) begin
                    nxt_opnd_data[(2*j+p)*32 +: 32] = reg_read_data[(2*j+p)*32 +: 32];
                    nxt_opnd_is_rsid[2*j+p]         = reg_read_is_rsid[2*j+p];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the held payload is reset along with out_valid so a stalled
            // group never leaks stale data after reset.
            out_valid           <= 1'b0;
            out_lane_mask       <= '0;
            out_pc              <= '0;
            out_inst            <= '0;
            out_is_branch_taken <= '0;
            out_pht_index       <= '0;
            out_opnd_en         <= '0;
            out_opnd_data       <= '0;
            out_opnd_is_rsid    <= '0;
            out_opnd_dep        <= '0;
            out_opnd_dep_lane   <= '0;
            out_write_en        <= '0;
            out_write_addr      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid           <= 1'b1;
            out_lane_mask       <= in_lane_mask;
            out_pc              <= nxt_pc;
            out_inst            <= nxt_inst;
            out_is_branch_taken <= nxt_bt;
            out_pht_index       <= nxt_pht;
            out_opnd_en         <= nxt_opnd_en;
            out_opnd_data       <= nxt_opnd_data;
            out_opnd_is_rsid    <= nxt_opnd_is_rsid;
            out_opnd_dep        <= nxt_opnd_dep;
            out_opnd_dep_lane   <= nxt_opnd_dep_lane;
            out_write_en        <= nxt_write_en;
            out_write_addr      <= nxt_write_addr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_group_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (perf_clear) begin
            perf_group_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) perf_group_cnt <= perf_group_cnt + 32'd1;
            if (in_valid && !in_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_wide.sv
// Directed testbench for id_wide (WIDTH=2) with a small regfile model on the read ports.
module tb_id_wide;
    localparam int WIDTH = 2;
    localparam int LW    = 1;

    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_ADDIU = 32'h24640001;
    localparam logic [31:0] I_JAL   = 32'h0C000010;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_LW    = 32'h8D250004;
    localparam logic [31:0] I_SW    = 32'hACC50000;
    localparam logic [31:0] I_LUI   = 32'h3C070012;
    localparam logic [31:0] I_BEQ   = 32'h10220003;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [WIDTH-1:0] in_lane_mask = '0;
    logic [WIDTH*32-1:0] in_pc = '0;
    logic [WIDTH*32-1:0] in_inst = '0;
    logic [WIDTH-1:0] in_is_branch_taken = '0;
    logic [WIDTH*5-1:0] in_pht_index = '0;
    logic [2*WIDTH-1:0] reg_read_en;
    logic [2*WIDTH*5-1:0] reg_read_addr;
    logic [2*WIDTH-1:0] reg_read_is_rsid;
    logic [2*WIDTH*32-1:0] reg_read_data;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [WIDTH-1:0] out_lane_mask;
    logic [WIDTH*32-1:0] out_pc;
    logic [WIDTH*32-1:0] out_inst;
    logic [WIDTH-1:0] out_is_branch_taken;
    logic [WIDTH*5-1:0] out_pht_index;
    logic [2*WIDTH-1:0] out_opnd_en;
    logic [2*WIDTH*32-1:0] out_opnd_data;
    logic [2*WIDTH-1:0] out_opnd_is_rsid;
    logic [2*WIDTH-1:0] out_opnd_dep;
    logic [2*WIDTH*LW-1:0] out_opnd_dep_lane;
    logic [WIDTH-1:0] out_write_en;
    logic [WIDTH*5-1:0] out_write_addr;
`ifdef ID_PERF_CNT_EN
    logic perf_clear = 1'b0;
    logic [31:0] perf_group_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];
    logic [31:0] rsid_bits;

    id_wide #(.WIDTH(WIDTH), .ADDR_W(32), .GHR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef ID_PERF_CNT_EN
        .perf_clear(perf_clear), .perf_group_cnt(perf_group_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_mask(in_lane_mask), .in_pc(in_pc),
        .in_inst(in_inst), .in_is_branch_taken(in_is_branch_taken), .in_pht_index(in_pht_index),
        .reg_read_en(reg_read_en), .reg_read_addr(reg_read_addr),
        .reg_read_is_rsid(reg_read_is_rsid), .reg_read_data(reg_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_mask(out_lane_mask),
        .out_pc(out_pc), .out_inst(out_inst), .out_is_branch_taken(out_is_branch_taken),
        .out_pht_index(out_pht_index), .out_opnd_en(out_opnd_en), .out_opnd_data(out_opnd_data),
        .out_opnd_is_rsid(out_opnd_is_rsid), .out_opnd_dep(out_opnd_dep),
        .out_opnd_dep_lane(out_opnd_dep_lane), .out_write_en(out_write_en),
        .out_write_addr(out_write_addr)
    );

    always #5 clk = ~clk;

    always_comb begin
        reg_read_data    = '0;
        reg_read_is_rsid = '0;
        for (int p = 0; p < 2*WIDTH; p++) begin
            reg_read_data[p*32 +: 32] = regs[reg_read_addr[p*5 +: 5]];
            reg_read_is_rsid[p]       = rsid_bits[reg_read_addr[p*5 +: 5]];
        end
    end

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] i0, input logic [31:0] i1);
        in_valid           = v;
        in_lane_mask       = m;
        in_inst            = {i1, i0};
        in_pc              = {32'h0000_1004, 32'h0000_1000};
        in_is_branch_taken = 2'b10;
        in_pht_index       = {5'd17, 5'd3};
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        checks++; if (out_write_en !== 2'b00) begin errors++; $display("FAIL reset_write_en got=%0h exp=0", out_write_en); end
        checks++; if (out_opnd_data !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", out_opnd_data); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_decode_dep();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 2'b11, I_ADDU, I_ADDIU);
        #1;
        checks++; if (reg_read_en !== 4'b0111) begin errors++; $display("FAIL dd_read_en got=%0h exp=7", reg_read_en); end
        checks++; if (reg_read_addr !== {5'd0, 5'd3, 5'd2, 5'd1}) begin errors++; $display("FAIL dd_read_addr got=%0h exp=%0h", reg_read_addr, {5'd0, 5'd3, 5'd2, 5'd1}); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dd_valid got=%0h exp=1", out_valid); end
        checks++; if (out_opnd_data[63:0] !== {32'd7, 32'd5}) begin errors++; $display("FAIL dd_data got=%0h exp=700000005", out_opnd_data[63:0]); end
        checks++; if (out_opnd_en !== 4'b0111) begin errors++; $display("FAIL dd_opnd_en got=%0h exp=7", out_opnd_en); end
        checks++; if (out_opnd_dep !== 4'b0100) begin errors++; $display("FAIL dd_dep got=%0h exp=4", out_opnd_dep); end
        checks++; if (out_opnd_dep_lane[2] !== 1'b0) begin errors++; $display("FAIL dd_dep_lane got=%0h exp=0", out_opnd_dep_lane[2]); end
        checks++; if (out_opnd_is_rsid !== 4'b0000) begin errors++; $display("FAIL dd_rsid got=%0h exp=0", out_opnd_is_rsid); end
        checks++; if (out_write_en !== 2'b11) begin errors++; $display("FAIL dd_write_en got=%0h exp=3", out_write_en); end
        checks++; if (out_write_addr !== {5'd4, 5'd3}) begin errors++; $display("FAIL dd_write_addr got=%0h exp=83", out_write_addr); end
        checks++; if (out_pc !== {32'h1004, 32'h1000}) begin errors++; $display("FAIL dd_pc got=%0h", out_pc); end
        checks++; if (out_is_branch_taken !== 2'b10 || out_pht_index !== {5'd17, 5'd3}) begin errors++; $display("FAIL dd_pred got=%0h/%0h exp=2/223", out_is_branch_taken, out_pht_index); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dd_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_jal();
        @(negedge clk);
        drive(1'b1, 2'b11, I_JAL, I_NOP);
        #1;
        checks++; if (reg_read_en !== 4'b0000) begin errors++; $display("FAIL jal_read_en got=%0h exp=0", reg_read_en); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        checks++; if (out_write_en !== 2'b01) begin errors++; $display("FAIL jal_write_en got=%0h exp=1", out_write_en); end
        checks++; if (out_write_addr !== {5'd0, 5'd31}) begin errors++; $display("FAIL jal_write_addr got=%0h exp=1f", out_write_addr); end
        checks++; if (out_opnd_en !== 4'b0000) begin errors++; $display("FAIL jal_opnd_en got=%0h exp=0", out_opnd_en); end
    endtask

    task automatic test_lane_mask();
        @(negedge clk);
        drive(1'b1, 2'b01, I_ADDU, I_ADDIU);
        #1;
        checks++; if (reg_read_en !== 4'b0011) begin errors++; $display("FAIL mask_read_en got=%0h exp=3", reg_read_en); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        checks++; if (out_opnd_en !== 4'b0011 || out_opnd_dep !== 4'b0000) begin errors++; $display("FAIL mask_opnd got=%0h/%0h exp=3/0", out_opnd_en, out_opnd_dep); end
        checks++; if (out_write_en !== 2'b01) begin errors++; $display("FAIL mask_write_en got=%0h exp=1", out_write_en); end
        checks++; if (out_inst[63:32] !== 32'd0 || out_pc[63:32] !== 32'd0 || out_is_branch_taken[1] !== 1'b0) begin errors++; $display("FAIL mask_lane1 got=%0h/%0h/%0h exp=0", out_inst[63:32], out_pc[63:32], out_is_branch_taken[1]); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 2'b11, I_LW, I_SW);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 2'b11, I_LUI, I_BEQ);
        #1;
        checks++; if (in_ready !== 1'b0 || reg_read_en !== 4'b0000) begin errors++; $display("FAIL stall_in_ready got=%0h/%0h exp=0/0", in_ready, reg_read_en); end
        checks++; if (out_opnd_en !== 4'b1101 || out_opnd_dep !== 4'b1000 || out_opnd_is_rsid !== 4'b0001) begin errors++; $display("FAIL stall_g1_opnd got=%0h/%0h/%0h exp=d/8/1", out_opnd_en, out_opnd_dep, out_opnd_is_rsid); end
        checks++; if (out_opnd_data[31:0] !== 32'h99 || out_opnd_data[95:64] !== 32'h66) begin errors++; $display("FAIL stall_g1_data got=%0h/%0h exp=99/66", out_opnd_data[31:0], out_opnd_data[95:64]); end
        checks++; if (out_write_addr !== {5'd0, 5'd5} || out_opnd_dep_lane[3] !== 1'b0) begin errors++; $display("FAIL stall_g1_wr got=%0h/%0h exp=5/0", out_write_addr, out_opnd_dep_lane[3]); end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_inst !== {I_SW, I_LW}) begin errors++; $display("FAIL stall_hold got=%0h/%0h exp=1/%0h", out_valid, out_inst, {I_SW, I_LW}); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%0h exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        checks++; if (out_valid !== 1'b1 || out_inst !== {I_BEQ, I_LUI}) begin errors++; $display("FAIL stall_g2 got=%0h/%0h exp=1/%0h", out_valid, out_inst, {I_BEQ, I_LUI}); end
        checks++; if (out_opnd_en !== 4'b1100 || out_write_en !== 2'b01 || out_write_addr !== {5'd0, 5'd7}) begin errors++; $display("FAIL stall_g2_dec got=%0h/%0h/%0h exp=c/1/7", out_opnd_en, out_write_en, out_write_addr); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 2'b11, I_ADDU, I_ADDIU);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2'b11, I_JAL, I_NOP);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
        checks++; if (out_inst !== {I_ADDIU, I_ADDU}) begin errors++; $display("FAIL flush_not_captured got=%0h exp=%0h", out_inst, {I_ADDIU, I_ADDU}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays got=%0h exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 2'b11, I_ADDU, I_ADDIU);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 2'b11, I_JAL, I_NOP);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_inst !== '0 || out_write_en !== 2'b00) begin errors++; $display("FAIL rst_async got=%0h/%0h/%0h exp=0/0/0", out_valid, out_inst, out_write_en); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        out_ready = 1'b1;
        drive(1'b1, 2'b11, I_ADDU, I_ADDIU);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'b00, I_NOP, I_NOP);
        checks++; if (out_valid !== 1'b1 || out_opnd_dep !== 4'b0100 || out_write_addr !== {5'd4, 5'd3}) begin errors++; $display("FAIL rst_first got=%0h/%0h/%0h exp=1/4/83", out_valid, out_opnd_dep, out_write_addr); end
        checks++; if (out_opnd_data[31:0] !== 32'd5) begin errors++; $display("FAIL rst_first_data got=%0h exp=5", out_opnd_data[31:0]); end
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef ID_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        perf_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        perf_clear = 1'b0;
        drive(1'b1, 2'b11, I_ADDU, I_ADDIU);
        repeat (4) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (perf_group_cnt !== 32'd4) begin errors++; $display("FAIL perf_group got=%0d exp=4", perf_group_cnt); end
        checks++; if (perf_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt); end
        out_ready  = 1'b1;
        perf_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        perf_clear = 1'b0;
        checks++; if (perf_group_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", perf_group_cnt, perf_stall_cnt); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h100 + r;
        regs[0]   = 32'd0;
        regs[1]   = 32'd5;
        regs[2]   = 32'd7;
        regs[6]   = 32'h66;
        regs[9]   = 32'h99;
        rsid_bits = 32'h0000_0200;
        test_reset();
        test_decode_dep();
        test_jal();
        test_lane_mask();
        test_stall();
        test_flush();
        test_reset_mid_stall();
`ifdef ID_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
